// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_seq
// Purpose  : Multi-cycle IEEE-754 single-precision divider z = a / b.
//            Restoring mantissa division, valid/ready handshakes on both
//            sides, one operation in flight. Denormal inputs read as zero.
// Ports    : clk        rising-edge clock
//            rst        synchronous, active-high reset (aborts any operation)
//            in_valid   a/b valid          in_ready   idle, operands accepted
//            a, b       dividend / divisor (IEEE-754 single)
//            out_valid  z/status valid, held until out_ready
//            out_ready  consumer accepts result
//            z          quotient
//            status     {0, div_by_zero, inexact, huge, tiny, nan, inf, zero}
// Config   : FP_DIV_RADIX4_EN - two restoring steps per DIV cycle
//            (13 DIV cycles instead of 26, identical results)
// Revision : 1.0 - initial release
// ============================================================================
package fp_div_seq_pkg;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_values;
endpackage

module fp_div_seq
    import fp_div_seq_pkg::*;
#(
    parameter round_values RND = IEEE_near
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [7:0]  status
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PREP = 3'd1;
    localparam logic [2:0] c_DIV  = 3'd2;
    localparam logic [2:0] c_RND  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;
`ifdef FP_DIV_RADIX4_EN
    localparam logic [4:0] c_DIV_LAST = 5'd12;
`else
    localparam logic [4:0] c_DIV_LAST = 5'd25;
`endif

    logic [2:0]        state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [24:0]       rem_q, rem_d;
    logic [25:0]       quo_q, quo_d;
    logic signed [9:0] exp_q, exp_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       z_q, z_d;
    logic [7:0]        status_q, status_d;

    // One restoring step: returns {quotient bit, next (shifted) remainder}.
    // The kept remainder is always below the divisor, so bit 24 drops out.
    function automatic logic [25:0] div_step(input logic [24:0] rem, input logic [23:0] dvs);
        logic [25:0] diff;
        logic [24:0] keep;
        logic [24:0] nxt;
        diff = {1'b0, rem} - {2'b00, dvs};
        keep = diff[25] ? rem : diff[24:0];
        nxt  = keep << 1;
        return {~diff[25], nxt};
    endfunction

    // ---------------- operand classification ----------------
    logic        w_sign, w_special;
    logic        w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic [23:0] w_mb;

    assign w_sign    = a_q[31] ^ b_q[31];
    assign w_a_zero  = (a_q[30:23] == 8'h00);
    assign w_b_zero  = (b_q[30:23] == 8'h00);
    assign w_a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign w_b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign w_a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign w_b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    assign w_special = w_a_zero | w_b_zero | (a_q[30:23] == 8'hFF) | (b_q[30:23] == 8'hFF);
    assign w_mb      = {1'b1, b_q[22:0]};

    // Special-operand result; flags are {dbz, inexact, huge, tiny, nan}.
    logic [31:0] w_spec_z;
    logic [4:0]  w_spec_flg;

    always_comb begin
        w_spec_z   = {w_sign, 31'd0};
        w_spec_flg = 5'b00000;
        if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
            w_spec_z   = 32'h7FC0_0000;
            w_spec_flg = 5'b00001;
        end else if (w_b_zero & ~w_a_inf) begin
            w_spec_z   = {w_sign, 8'hFF, 23'd0};
            w_spec_flg = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_z   = {w_sign, 8'hFF, 23'd0};
        end
        // 0/x and finite/inf keep the signed-zero default
    end

    // ---------------- normalisation and rounding ----------------
    logic [22:0]       w_mant, w_mant_r;
    logic              w_guard, w_sticky, w_inexact, w_inc, w_tiny_up;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic [31:0]       w_rnd_z;
    logic [4:0]        w_rnd_flg;

    always_comb begin
        w_mant    = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
        w_guard   = quo_q[25] ? quo_q[1]    : quo_q[0];
        w_sticky  = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
        w_exp_n   = quo_q[25] ? exp_q : exp_q - 10'sd1;
        w_inexact = w_guard | w_sticky;
        // A quotient of two 24-bit mantissas can never land exactly on a
        // half-ulp, so the two nearest modes coincide in practice.
        case (RND)
            IEEE_near: w_inc = w_guard & (w_sticky | w_mant[0]);
            IEEE_zero: w_inc = 1'b0;
            IEEE_pinf: w_inc = w_inexact & ~w_sign;
            IEEE_ninf: w_inc = w_inexact & w_sign;
            near_up:   w_inc = w_guard;
            default:   w_inc = w_inexact;
        endcase
        w_sum     = {2'b01, w_mant} + {24'd0, w_inc};
        w_mant_r  = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
        w_exp_r   = w_exp_n + $signed({9'd0, w_sum[24]});
        w_tiny_up = ((RND == IEEE_pinf) & ~w_sign) | ((RND == IEEE_ninf) & w_sign) |
                    (RND == away_zero);

        w_rnd_z   = {w_sign, w_exp_r[7:0], w_mant_r};
        w_rnd_flg = {1'b0, w_inexact, 3'b000};
        if (w_exp_r >= 10'sd255) begin
            w_rnd_flg = 5'b01100;
            case (RND)
                IEEE_zero: w_rnd_z = {w_sign, 8'hFE, 23'h7FFFFF};
                IEEE_pinf: w_rnd_z = w_sign ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
                IEEE_ninf: w_rnd_z = w_sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
                default:   w_rnd_z = {w_sign, 8'hFF, 23'd0};
            endcase
        end else if (w_exp_r <= 10'sd0) begin
            w_rnd_flg = 5'b01010;
            w_rnd_z   = w_tiny_up ? {w_sign, 8'h01, 23'd0} : {w_sign, 31'd0};
        end
    end

    // Result mux: PREP only completes for specials, RND for the normal path.
    logic [31:0] w_res_z;
    logic [7:0]  w_res_status;

    always_comb begin
        w_res_z = (state_q == c_PREP) ? w_spec_z : w_rnd_z;
        w_res_status = {1'b0, ((state_q == c_PREP) ? w_spec_flg : w_rnd_flg),
                        (w_res_z[30:23] == 8'hFF) && (w_res_z[22:0] == 23'd0),
                        (w_res_z[30:0] == 31'd0)};
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            status_q <= status_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (in_valid) state_d = c_PREP;
            c_PREP:  state_d = w_special ? c_DONE : c_DIV;
            c_DIV:   if (cnt_q == 5'd0) state_d = c_RND;
            c_RND:   state_d = c_DONE;
            c_DONE:  if (out_ready) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == c_IDLE);
        out_valid = (state_q == c_DONE);
    end

    assign z      = z_q;
    assign status = status_q;

    // ---------------- datapath next values ----------------
    logic [25:0] w_step1;
`ifdef FP_DIV_RADIX4_EN
    logic [25:0] w_step2;
`endif

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        status_d = status_q;
        w_step1  = div_step(rem_q, w_mb);
`ifdef FP_DIV_RADIX4_EN
        w_step2  = div_step(w_step1[24:0], w_mb);
`endif
        case (state_q)
            c_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                end
            end
            c_PREP: begin
                rem_d = {2'b01, a_q[22:0]};
                quo_d = '0;
                exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                cnt_d = c_DIV_LAST;
                if (w_special) begin
                    z_d      = w_res_z;
                    status_d = w_res_status;
                end
            end
            c_DIV: begin
`ifdef FP_DIV_RADIX4_EN
                rem_d = w_step2[24:0];
                quo_d = {quo_q[23:0], w_step1[25], w_step2[25]};
`else
                rem_d = w_step1[24:0];
                quo_d = {quo_q[24:0], w_step1[25]};
`endif
                cnt_d = cnt_q - 5'd1;
            end
            c_RND: begin
                z_d      = w_res_z;
                status_d = w_res_status;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_seq
// Purpose  : Self-checking bench for fp_div_seq. One DUT per rounding mode,
//            all sharing the operand/handshake inputs; results are compared
//            with an exact rational-arithmetic reference model.
// Config   : FP_DIV_RADIX4_EN selects the expected normal-path latency
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq;
    import fp_div_seq_pkg::*;

    localparam int c_NMODES = 6;
`ifdef FP_DIV_RADIX4_EN
    localparam int c_LAT_NORM = 15;
`else
    localparam int c_LAT_NORM = 28;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] a, b;
    logic        in_ready_w  [c_NMODES];
    logic        out_valid_w [c_NMODES];
    logic [31:0] z_w         [c_NMODES];
    logic [7:0]  status_w    [c_NMODES];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NMODES; g++) begin : g_dut
        fp_div_seq #(.RND(round_values'(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a         (a),
            .b         (b),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .z         (z_w[g]),
            .status    (status_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Reference: exact quotient via integer division, rounding decided by
    // comparing twice the remainder with the divisor. Returns {status, z}.
    // mode: 0 near-even, 1 toward zero, 2 +inf, 3 -inf, 4 near-up, 5 away.
    function automatic logic [39:0] ref_div(input logic [31:0] av, input logic [31:0] bv, input int mode);
        int          ea, eb, e;
        longint      ma, mb, num, q, r;
        bit          s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        bit          inexact, above, tie, inc, away;
        logic [31:0] zz;
        logic [7:0]  st;
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        s  = av[31] ^ bv[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (av[22:0] == 23'd0);
        b_inf  = (eb == 255) && (bv[22:0] == 23'd0);
        a_nan  = (ea == 255) && (av[22:0] != 23'd0);
        b_nan  = (eb == 255) && (bv[22:0] != 23'd0);
        st = 8'h00;
        zz = {s, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            zz = 32'h7FC0_0000;
            st = 8'h04;
        end else if (b_zero && !a_inf) begin
            zz = {s, 8'hFF, 23'd0};
            st = 8'h40;
        end else if (a_inf) begin
            zz = {s, 8'hFF, 23'd0};
        end else if (!(a_zero || b_inf)) begin
            ma = longint'({1'b1, av[22:0]});
            mb = longint'({1'b1, bv[22:0]});
            e  = ea - eb + 127;
            if (ma < mb) begin
                num = ma << 24;
                e   = e - 1;
            end else begin
                num = ma << 23;
            end
            q = num / mb;
            r = num % mb;
            above   = (2 * r > mb);
            tie     = (2 * r == mb);
            inexact = (r != 0);
            case (mode)
                0:       inc = above || (tie && q[0]);
                1:       inc = 1'b0;
                2:       inc = inexact && !s;
                3:       inc = inexact && s;
                4:       inc = above || tie;
                default: inc = inexact;
            endcase
            if (inc) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                st = 8'h30;
                case (mode)
                    1:       zz = {s, 8'hFE, 23'h7FFFFF};
                    2:       zz = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
                    3:       zz = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                    default: zz = {s, 8'hFF, 23'd0};
                endcase
            end else if (e <= 0) begin
                st   = 8'h28;
                away = (mode == 5) || (mode == 2 && !s) || (mode == 3 && s);
                zz   = away ? {s, 8'h01, 23'd0} : {s, 31'd0};
            end else begin
                zz = {s, 8'(e), q[22:0]};
                st = inexact ? 8'h20 : 8'h00;
            end
        end
        st[0] = (zz[30:0] == 31'd0);
        st[1] = (zz[30:23] == 8'hFF) && (zz[22:0] == 23'd0);
        return {st, zz};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'h00;
            1:       v[30:23] = 8'hFF;
            2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            3:       v[30:0] = 31'd0;
            4:       v[30:23] = 8'($urandom_range(200, 254));
            5:       v[30:23] = 8'($urandom_range(1, 50));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Issue one operation, measure latency, compare every mode with the model.
    // Leaves the result pending (out_ready low).
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string tag);
        int          k, lat;
        logic [39:0] ev;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready_w[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s.in_ready", tag), {31'd0, in_ready_w[0]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = ((av[30:23] == 8'h00) || (av[30:23] == 8'hFF) ||
               (bv[30:23] == 8'h00) || (bv[30:23] == 8'hFF)) ? 1 : c_LAT_NORM;
        k = 0;
        while (!out_valid_w[0] && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("%s.latency", tag), 32'(k), 32'(lat));
        for (int m = 0; m < c_NMODES; m++) begin
            ev = ref_div(av, bv, m);
            chk($sformatf("%s.z[m%0d] a=%08h b=%08h", tag, m, av, bv), z_w[m], ev[31:0]);
            chk($sformatf("%s.status[m%0d] a=%08h b=%08h", tag, m, av, bv), {24'd0, status_w[m]}, {24'd0, ev[39:32]});
        end
    endtask

    task automatic release_out(input bit check_hs);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (check_hs) begin
            chk("hs.in_ready", {31'd0, in_ready_w[0]}, 32'd1);
            chk("hs.out_valid", {31'd0, out_valid_w[0]}, 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] av, bv;
        bit          seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < c_NMODES; m++) begin
            chk($sformatf("reset.in_ready[m%0d]", m), {31'd0, in_ready_w[m]}, 32'd1);
            chk($sformatf("reset.out_valid[m%0d]", m), {31'd0, out_valid_w[m]}, 32'd0);
            chk($sformatf("reset.z[m%0d]", m), z_w[m], 32'd0);
            chk($sformatf("reset.status[m%0d]", m), {24'd0, status_w[m]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 6.0 / 2.0
        run_op(32'h40C0_0000, 32'h4000_0000, "six_by_two");
        chk("six_by_two.z_near", z_w[0], 32'h4040_0000);
        chk("six_by_two.st_near", {24'd0, status_w[0]}, 32'h00);
        release_out(1'b1);

        // 1/3: truncation vs nearest
        run_op(32'h3F80_0000, 32'h4040_0000, "third");
        chk("third.z_zero", z_w[1], 32'h3EAA_AAAA);
        chk("third.z_near", z_w[0], 32'h3EAA_AAAB);
        chk("third.st_zero", {24'd0, status_w[1]}, 32'h20);
        chk("third.st_near", {24'd0, status_w[0]}, 32'h20);
        // backpressure: result held, no new operand accepted
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.z", z_w[0], 32'h3EAA_AAAB);
            chk("bp.status", {24'd0, status_w[0]}, 32'h20);
            chk("bp.in_ready", {31'd0, in_ready_w[0]}, 32'd0);
            chk("bp.out_valid", {31'd0, out_valid_w[0]}, 32'd1);
        end
        release_out(1'b1);

        // division by zero and 0/0
        run_op(32'h3F80_0000, 32'h0000_0000, "one_by_zero");
        chk("one_by_zero.z", z_w[0], 32'h7F80_0000);
        chk("one_by_zero.st", {24'd0, status_w[0]}, 32'h42);
        release_out(1'b0);
        run_op(32'h0000_0000, 32'h0000_0000, "zero_by_zero");
        chk("zero_by_zero.z", z_w[0], 32'h7FC0_0000);
        chk("zero_by_zero.st", {24'd0, status_w[0]}, 32'h04);
        release_out(1'b0);

        // overflow
        run_op(32'h7F00_0000, 32'h0080_0000, "overflow");
        chk("overflow.z_zero", z_w[1], 32'h7F7F_FFFF);
        chk("overflow.st_zero", {24'd0, status_w[1]}, 32'h30);
        chk("overflow.z_near", z_w[0], 32'h7F80_0000);
        chk("overflow.st_near", {24'd0, status_w[0]}, 32'h32);
        release_out(1'b0);

        // underflow: min-normal / max
        run_op(32'h0080_0000, 32'h7F00_0000, "underflow");
        chk("underflow.z_near", z_w[0], 32'h0000_0000);
        chk("underflow.st_near", {24'd0, status_w[0]}, 32'h29);
        chk("underflow.z_away", z_w[5], 32'h0080_0000);
        chk("underflow.st_away", {24'd0, status_w[5]}, 32'h28);
        release_out(1'b0);
        run_op(32'h8080_0000, 32'h7F00_0000, "underflow_neg");
        chk("underflow_neg.z_ninf", z_w[3], 32'h8080_0000);
        chk("underflow_neg.z_pinf", z_w[2], 32'h8000_0000);
        release_out(1'b0);

        // reset in the middle of DIV aborts the operation
        @(negedge clk);
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_abort.in_ready", {31'd0, in_ready_w[0]}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_w[0]) seen = 1'b1;
        end
        chk("rst_abort.out_valid_seen", {31'd0, seen}, 32'd0);
        run_op(32'h40C0_0000, 32'h4000_0000, "after_rst");
        release_out(1'b1);

        // randomized operands against the model
        for (int i = 0; i < 150; i++) begin
            av = rnd_fp();
            bv = rnd_fp();
            run_op(av, bv, "rand");
            release_out(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
